// File: rtl/ac97_cmd_sched.sv
// AC97 command-slot scheduler: power-up register initialisation, then volume and
// record-source updates and round-robin external register writes, each held HOLD frames.
module ac97_cmd_sched #(
  parameter int NREQ        = 4,
  parameter int HOLD        = 2,
  parameter int WAIT_FRAMES = 4
) (
  input  logic                 clock_27mhz,
  input  logic                 reset,
  input  logic                 ready,
  input  logic [4:0]           volume,
  input  logic                 insource,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    req_addr,
  input  logic [16*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      grant,
  output logic [7:0]           command_address,
  output logic [15:0]          command_data,
  output logic                 command_valid,
  output logic                 busy,
  output logic                 init_done
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int WW = (WAIT_FRAMES > 1) ? $clog2(WAIT_FRAMES) : 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_FRAMES - 1);
  localparam logic [IW-1:0] RR_RESET  = IW'(NREQ - 1);
  localparam logic [2:0]    ROM_LAST  = 3'd4;
  localparam logic [23:0]   FILLER    = 24'h80_0000;

  typedef enum logic [1:0] {S_WAIT, S_INIT, S_SHADOW, S_RUN} state_t;

  function automatic logic [23:0] rom_word(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'h18_0808;
      3'd1:    return 24'h1C_0F0F;
      3'd2:    return 24'h0E_8048;
      3'd3:    return 24'h0A_0000;
      default: return 24'h20_8000;
    endcase
  endfunction

  function automatic logic [23:0] vol_word(input logic [4:0] vol);
    logic [4:0] att;
    att = 5'd31 - vol;
    return {8'h04, 3'b000, att, 3'b000, att};
  endfunction

  function automatic logic [23:0] src_word(input logic src);
    return {8'h1A, 5'b00000, src, 2'b00, 5'b00000, src, 2'b00};
  endfunction

  state_t          r_state, w_state_nx;
  logic [WW-1:0]   r_wait_cnt, w_wait_nx;
  logic [HW-1:0]   r_hold_cnt, w_hold_nx;
  logic [2:0]      r_rom_idx, w_rom_nx;
  logic            r_src_phase, w_src_phase_nx;
  logic            r_ext_active, w_ext_active_nx;
  logic [IW-1:0]   r_ext_idx, w_ext_idx_nx;
  logic [IW-1:0]   r_rr_ptr, w_rr_nx;
  logic [4:0]      r_shadow_vol, w_shadow_vol_nx;
  logic            r_shadow_src, w_shadow_src_nx;
  logic [23:0]     r_word, w_word_nx;
  logic            r_valid, w_valid_nx;
  logic            r_busy, w_busy_nx;
  logic            r_init_done, w_init_nx;
  logic [NREQ-1:0] r_grant, w_grant_nx;

  logic            w_retire, w_arb, w_load, w_pick_ok;
  logic [23:0]     w_load_word, w_pick_word;
  logic [IW-1:0]   w_pick_idx;
  logic [NREQ-1:0] w_req_elig;

  always_comb begin
    // NOTE: every variable gets a default first, so no path through this block can infer a latch.
    w_state_nx      = r_state;
    w_wait_nx       = r_wait_cnt;
    w_hold_nx       = r_hold_cnt;
    w_rom_nx        = r_rom_idx;
    w_src_phase_nx  = r_src_phase;
    w_ext_active_nx = r_ext_active;
    w_ext_idx_nx    = r_ext_idx;
    w_rr_nx         = r_rr_ptr;
    w_shadow_vol_nx = r_shadow_vol;
    w_shadow_src_nx = r_shadow_src;
    w_word_nx       = r_word;
    w_valid_nx      = r_valid;
    w_busy_nx       = r_busy;
    w_init_nx       = r_init_done;
    w_grant_nx      = '0;
    w_load          = 1'b0;
    w_load_word     = FILLER;
    w_arb           = 1'b0;

    w_retire = ready && r_busy && (r_hold_cnt == '0);
    if (ready && r_busy && (r_hold_cnt != '0)) w_hold_nx = r_hold_cnt - 1'b1;
    if (w_retire && r_ext_active) begin
      w_grant_nx[r_ext_idx] = 1'b1;
      w_ext_active_nx       = 1'b0;
    end

    // The requester being granted on this pulse still shows its old request.
    w_req_elig = req;
    if (w_retire && r_ext_active) w_req_elig[r_ext_idx] = 1'b0;

    w_pick_ok   = 1'b0;
    w_pick_idx  = r_rr_ptr;
    w_pick_word = FILLER;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_pick_ok && w_req_elig[i] && (i > int'(r_rr_ptr))) begin
        w_pick_ok   = 1'b1;
        w_pick_idx  = IW'(i);
        w_pick_word = {req_addr[8*i +: 8], req_data[16*i +: 16]};
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_pick_ok && w_req_elig[i] && (i <= int'(r_rr_ptr))) begin
        w_pick_ok   = 1'b1;
        w_pick_idx  = IW'(i);
        w_pick_word = {req_addr[8*i +: 8], req_data[16*i +: 16]};
      end
    end

    unique case (r_state)
      S_WAIT: if (ready) begin
        if (r_wait_cnt == WAIT_LAST) begin
          w_load      = 1'b1;
          w_load_word = rom_word(3'd0);
          w_rom_nx    = 3'd0;
          w_state_nx  = S_INIT;
        end else begin
          w_wait_nx = r_wait_cnt + 1'b1;
        end
      end
      S_INIT: if (w_retire) begin
        w_load = 1'b1;
        if (r_rom_idx == ROM_LAST) begin
          w_load_word     = vol_word(volume);
          w_shadow_vol_nx = volume;
          w_src_phase_nx  = 1'b0;
          w_state_nx      = S_SHADOW;
        end else begin
          w_rom_nx    = r_rom_idx + 3'd1;
          w_load_word = rom_word(r_rom_idx + 3'd1);
        end
      end
      S_SHADOW: if (w_retire) begin
        if (!r_src_phase) begin
          w_load          = 1'b1;
          w_load_word     = src_word(insource);
          w_shadow_src_nx = insource;
          w_src_phase_nx  = 1'b1;
        end else begin
          w_init_nx  = 1'b1;
          w_state_nx = S_RUN;
          w_arb      = 1'b1;
        end
      end
      S_RUN:   w_arb = ready && (!r_busy || (r_hold_cnt == '0));
      default: w_state_nx = S_WAIT;
    endcase

    if (w_arb) begin
      if (volume != r_shadow_vol) begin
        w_load          = 1'b1;
        w_load_word     = vol_word(volume);
        w_shadow_vol_nx = volume;
      end else if (insource != r_shadow_src) begin
        w_load          = 1'b1;
        w_load_word     = src_word(insource);
        w_shadow_src_nx = insource;
      end else if (w_pick_ok) begin
        w_load          = 1'b1;
        w_load_word     = w_pick_word;
        w_ext_active_nx = 1'b1;
        w_ext_idx_nx    = w_pick_idx;
        w_rr_nx         = w_pick_idx;
      end else begin
        w_word_nx  = FILLER;
        w_valid_nx = 1'b1;
        w_busy_nx  = 1'b0;
      end
    end

    if (w_load) begin
      w_word_nx  = w_load_word;
      w_valid_nx = 1'b1;
      w_busy_nx  = 1'b1;
      w_hold_nx  = HOLD_LOAD;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_27mhz or posedge reset) begin
    if (reset) begin
      r_state      <= S_WAIT;
      r_wait_cnt   <= '0;
      r_hold_cnt   <= '0;
      r_rom_idx    <= '0;
      r_src_phase  <= 1'b0;
      r_ext_active <= 1'b0;
      r_ext_idx    <= '0;
      r_rr_ptr     <= RR_RESET;
      r_shadow_vol <= '0;
      r_shadow_src <= 1'b0;
      r_word       <= FILLER;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_init_done  <= 1'b0;
      r_grant      <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_wait_cnt   <= w_wait_nx;
      r_hold_cnt   <= w_hold_nx;
      r_rom_idx    <= w_rom_nx;
      r_src_phase  <= w_src_phase_nx;
      r_ext_active <= w_ext_active_nx;
      r_ext_idx    <= w_ext_idx_nx;
      r_rr_ptr     <= w_rr_nx;
      r_shadow_vol <= w_shadow_vol_nx;
      r_shadow_src <= w_shadow_src_nx;
      r_word       <= w_word_nx;
      r_valid      <= w_valid_nx;
      r_busy       <= w_busy_nx;
      r_init_done  <= w_init_nx;
      r_grant      <= w_grant_nx;
    end
  end

  assign command_address = r_word[23:16];
  assign command_data    = r_word[15:0];
  assign command_valid   = r_valid;
  assign busy            = r_busy;
  assign init_done       = r_init_done;
  assign grant           = r_grant;

endmodule

// File: doc/ac97_cmd_sched.md
# ac97_cmd_sched

Codec command-slot scheduler for the AC97 frame engine. It drives the `command_address`/`command_data`/`command_valid` inputs of the `ac97` serializer, which latches them once per frame. It sequences a power-up register initialisation, then shares the single command slot between two sources: internally generated volume and record-source updates, and up to NREQ external register-write requesters. It replaces the free-running `ac97commands` loop: registers are written only when something changes, and every command is held long enough to be latched.

## Interface
- NREQ, 4: number of external requesters (1..8)
- HOLD, 2: frames (ready pulses) each command is held on the outputs (≥1)
- WAIT_FRAMES, 4: ready pulses to wait after reset before the first command
- clock_27mhz  in  1  system clock
- reset  in  1  asynchronous, active-high
- ready  in  1  one-cycle frame strobe, 48 kHz, synchronous to clock_27mhz
- volume  in  5  headphone volume, 31 = loudest
- insource  in  1  record source: 0 = mic, 1 = line
- req  in  NREQ  per-requester write request, level
- req_addr  in  8*NREQ  register address, requester i at [8i+7:8i]
- req_data  in  16*NREQ  register data, requester i at [16i+15:16i]
- grant  out  NREQ  one-cycle pulse, requester i's write is complete
- command_address  out  8  to ac97
- command_data  out  16  to ac97
- command_valid  out  1  to ac97
- busy  out  1  non-filler command in flight
- init_done  out  1  initialisation sequence finished

## Operation
- States: WAIT → INIT → SHADOW → RUN.
- WAIT: `command_valid`=0. Count ready pulses. On the WAIT_FRAMES-th pulse, load ROM entry 0 and go to INIT.
- INIT: issue the ROM entries in order, HOLD frames each:
  - 0x18_0808 (PCM volume)
  - 0x1C_0F0F (record gain)
  - 0x0E_8048 (mic +20 dB)
  - 0x0A_0000 (beep volume)
  - 0x20_8000 (PCM bypass mix1)
- SHADOW: issue one volume command, then one source command, HOLD frames each. `init_done` goes to 1 on the ready pulse that retires the source command; the state then becomes RUN.
- Volume command: att = 31 − volume (5-bit), word = {8'h04, 3'b0, att, 3'b0, att}. The current volume is captured into shadow_vol when the command is loaded.
- Source command: s = {insource, 2'b00}, word = {8'h1A, 5'b0, s, 5'b0, s}. The current insource is captured into shadow_src when the command is loaded.
- RUN: an update is pending when volume ≠ shadow_vol or insource ≠ shadow_src; an external request is pending when its req=1. Dispatch happens only on a ready pulse, when the slot is free or is retiring on that pulse. Priority:
  1. volume update
  2. source update
  3. external requests, round-robin, search starting at rr_ptr+1 mod NREQ
- rr_ptr becomes the index that was dispatched. rr_ptr resets to NREQ−1, so index 0 is searched first.
- Filler: when nothing is pending, output 0x80_0000 with `command_valid`=1 (read of register 0x00) and `busy`=0.
- External handshake:
  - The requester holds req, addr and data stable until its grant pulse.
  - addr/data are captured at dispatch.
  - `grant[i]` pulses on the ready pulse that retires the command.
  - If req[i] is still 1 on the cycle after grant, it is a new request.
  - Deasserting req before dispatch withdraws the request. Deasserting it after dispatch has no effect; the command still completes and grant still pulses.

## Timing
- All outputs are registered. They change on the clock_27mhz edge after the ready cycle.
- Reset values:
  - `command_address`=0x80
  - `command_data`=0x0000
  - `command_valid`=0
  - `grant`=0
  - `busy`=0
  - `init_done`=0
  - all counters, pending state and rr_ptr cleared (rr_ptr = NREQ−1)
- Occupancy: each command is output for exactly HOLD frames, loaded on ready pulse k and retired on pulse k+HOLD. Back-to-back: the retire pulse also loads the next command, so there is no gap.
- Hold counter: 0..HOLD−1, decremented per ready pulse.
- Simultaneous events: a req, volume or insource change on the same cycle as a ready pulse is sampled and eligible on that pulse.
- A volume or source change during its own hold re-raises pending after that command is loaded. There is no intermediate-value tracking; only the latest value is sent.
- External requests arriving during WAIT, INIT or SHADOW stay pending. They are serviced in RUN.
- Reset mid-operation: all outputs return to reset values immediately, without waiting for a clock. No grant is issued for an in-flight command. The block restarts at WAIT.

## Test plan
- Power-up: reset, volume=31, insource=1, 4 ready pulses → `command_valid` stays 0. Then the five ROM words for 2 frames each, 0x04_0000 for 2 frames, 0x1A_0404 for 2 frames, then `init_done`=1 and filler 0x80_0000.
- Volume change: in RUN, volume 31→0 → on the next ready the output becomes 0x04_1F1F with `busy`=1 for 2 frames, then filler. No grant pulses.
- Round-robin: req=4'b1111, all held → grants 0,1,2,3,0, each 2 frames apart. Each command shows that requester's addr/data.
- Priority: volume change and req[2] asserted on the same ready cycle → volume word first, req[2] command next, grant[2] on its retire pulse.
- Withdrawal: req[1] asserted during INIT and dropped before RUN → never dispatched, no grant[1]. Asserted during INIT and kept → first dispatched in RUN after the shadow commands.
- Reset mid-hold: assert reset during an external hold → outputs go to reset values without a clock edge, no grant. After release, the full power-up sequence repeats.
